// File: rtl/psr_pkg.sv
// psr_pkg: shared state type and CPSR field layout for the status/banking unit.
package psr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_SWITCH  = 2'd2,
    ST_RESTORE = 2'd3
  } psr_state_e;

  // CPSR layout: [5:0] FP status, [9:6] N,C,Z,V, [12:10] mode, [13+j] source-j mask
  localparam int FPS_LSB   = 0;
  localparam int NZCV_LSB  = 6;
  localparam int MODE_LSB  = 10;
  localparam int MASK_LSB  = 13;
  localparam int MODE_W    = 3;

  // Vector table entries are 8 bytes apart
  localparam int VEC_SHIFT = 3;

endpackage

// File: rtl/psr_prio_enc.sv
// psr_prio_enc: picks the highest-numbered unmasked request whose target
// mode (source + 1) is above the current mode.
module psr_prio_enc
  import psr_pkg::*;
#(
  parameter int NSRC = 3
) (
  input  logic [NSRC-1:0]   req,
  input  logic [NSRC-1:0]   mask,
  input  logic [MODE_W-1:0] cur_mode,
  output logic              valid,
  output logic [MODE_W-1:0] index
);

  // Ascending scan so the last (highest) eligible source overrides lower ones
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int j = 0; j < NSRC; j++) begin
      if (req[j] && !mask[j] && (MODE_W'(j + 1) > cur_mode)) begin
        valid = 1'b1;
        index = MODE_W'(j);
      end
    end
  end

endmodule

// File: rtl/psr_bank_ctrl.sv
// psr_bank_ctrl: CPSR plus per-mode banked SPSR/LR with prioritised,
// nestable exception entry and return sequencing.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | accept flag/CPSR writes, arbitrate entry/return requests
// ST_SAVE    | bank CPSR into SPSR[k+1] and pc_in into LR[k+1]
// ST_SWITCH  | switch to mode k+1, mask sources 0..k, pulse exc_ack
// ST_RESTORE | reload CPSR from SPSR[mode], pulse ret_valid with LR[mode]
module psr_bank_ctrl
  import psr_pkg::*;
#(
  parameter int              DW       = 32,
  parameter int              NMODES   = 4,
  parameter logic [DW-1:0]   VEC_BASE = 32'h0000_0100
) (
  input  logic                W_Clk,
  input  logic                reset,
  input  logic [NMODES-2:0]   irq_req,
  input  logic                ret_req,
  input  logic [DW-1:0]       pc_in,
  input  logic                flags_ld,
  input  logic [9:0]          flags_in,
  input  logic                cpsr_wr,
  input  logic [DW-1:0]       cpsr_din,
  output logic [DW-1:0]       CPSR_out,
  output logic [MODE_W-1:0]   cur_mode,
  output logic                busy,
  output logic                exc_ack,
  output logic [DW-1:0]       exc_vec,
  output logic                ret_valid,
  output logic [DW-1:0]       ret_addr,
  output logic                ret_err
);

  localparam int NSRC = NMODES - 1;
  // Writable CPSR bits; everything above the last mask bit reads as zero
  localparam logic [DW-1:0] CPSR_WMASK = DW'((64'd1 << (MASK_LSB + NSRC)) - 64'd1);
  // All sources masked, user mode, flags clear
  localparam logic [DW-1:0] CPSR_RST   = DW'(((64'd1 << NSRC) - 64'd1) << MASK_LSB);

  psr_state_e        state;
  logic [MODE_W-1:0] k_lat;
  logic [DW-1:0]     cpsr;
  logic [DW-1:0]     spsr_bank [1:NMODES-1];
  logic [DW-1:0]     lr_bank   [1:NMODES-1];

  logic [DW-1:0]     cpsr_upd;
  logic [DW-1:0]     cpsr_sw;
  logic [DW-1:0]     spsr_rd;
  logic [DW-1:0]     lr_upd_rd;
  logic              enc_valid;
  logic [MODE_W-1:0] enc_idx;

  assign cur_mode = cpsr[MODE_LSB +: MODE_W];
  assign CPSR_out = cpsr;
  assign busy     = (state != ST_IDLE);

  psr_prio_enc #(.NSRC(NSRC)) u_prio (
    .req      (irq_req),
    .mask     (cpsr[MASK_LSB +: NSRC]),
    .cur_mode (cur_mode),
    .valid    (enc_valid),
    .index    (enc_idx)
  );

  // CPSR as it will be after this IDLE cycle's MSR / flag update
  always_comb begin
    cpsr_upd = cpsr;
    if (cpsr_wr) begin
      cpsr_upd = cpsr_din & CPSR_WMASK;
    end else if (flags_ld) begin
      cpsr_upd[FPS_LSB +: 6]  = flags_in[5:0];
      cpsr_upd[NZCV_LSB +: 4] = flags_in[9:6];
    end
  end

  // CPSR after entering mode k+1 with sources 0..k masked
  always_comb begin
    cpsr_sw = cpsr;
    cpsr_sw[MODE_LSB +: MODE_W] = k_lat + MODE_W'(1);
    for (int j = 0; j < NSRC; j++) begin
      if (MODE_W'(j) <= k_lat) cpsr_sw[MASK_LSB + j] = 1'b1;
    end
  end

  // Bank reads; mode 0 or an out-of-range mode has no bank and reads zero.
  // The LR lookup uses the post-update mode because an MSR in the cycle that
  // starts a return is honoured before RESTORE indexes the bank.
  always_comb begin
    spsr_rd   = '0;
    lr_upd_rd = '0;
    for (int i = 1; i < NMODES; i++) begin
      if (cur_mode == MODE_W'(i)) spsr_rd = spsr_bank[i];
      if (cpsr_upd[MODE_LSB +: MODE_W] == MODE_W'(i)) lr_upd_rd = lr_bank[i];
    end
  end

  // Sequencer, CPSR, banks and registered strobes
  always_ff @(posedge W_Clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      k_lat     <= '0;
      cpsr      <= CPSR_RST;
      exc_ack   <= 1'b0;
      exc_vec   <= '0;
      ret_valid <= 1'b0;
      ret_addr  <= '0;
      ret_err   <= 1'b0;
      for (int i = 1; i < NMODES; i++) begin
        spsr_bank[i] <= '0;
        lr_bank[i]   <= '0;
      end
    end else begin
      exc_ack   <= 1'b0;
      exc_vec   <= '0;
      ret_valid <= 1'b0;
      ret_addr  <= '0;
      ret_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          cpsr <= cpsr_upd;
          if (enc_valid) begin
            k_lat <= enc_idx;
            state <= ST_SAVE;
          end else if (ret_req && (cur_mode != '0)) begin
            state     <= ST_RESTORE;
            ret_valid <= 1'b1;
            ret_addr  <= lr_upd_rd;
          end else if (ret_req && !ret_err) begin
            // a held request must not re-fire while its error pulse is out
            ret_err <= 1'b1;
          end
        end
        ST_SAVE: begin
          for (int i = 1; i < NMODES; i++) begin
            if (k_lat + MODE_W'(1) == MODE_W'(i)) begin
              spsr_bank[i] <= cpsr;
              lr_bank[i]   <= pc_in;
            end
          end
          exc_ack <= 1'b1;
          exc_vec <= VEC_BASE + (DW'(k_lat) << VEC_SHIFT);
          state   <= ST_SWITCH;
        end
        ST_SWITCH: begin
          cpsr  <= cpsr_sw;
          state <= ST_IDLE;
        end
        ST_RESTORE: begin
          cpsr  <= spsr_rd;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/psr_bank_ctrl.md
# psr_bank_ctrl

Parametrised program-status and exception-banking unit for the CPU execution unit. It holds the CPSR together with one banked SPSR and one banked link register per exception mode. It arbitrates prioritised interrupt sources and sequences exception entry and return through a small state machine. It generalises the fixed CPSR/SPSR/SPSR_fiq/Link_fiq arrangement to NMODES modes with nesting and masking.

## Interface

Parameters:
- DW, 32, data/address width of CPSR, SPSR, LR, pc_in, vectors
- NMODES, 4, mode count including mode 0 (user); 2..8; NSRC = NMODES-1 interrupt sources
- VEC_BASE, 32'h0000_0100, base of exception vector table

Ports (reset is asynchronous, active-low; one clock):
- W_Clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous active-low reset
- irq_req  in  NSRC  level requests; source k enters mode k+1; held until exc_ack
- ret_req  in  1  level return request; held until ret_valid or ret_err
- pc_in  in  DW  return address captured on entry
- flags_ld  in  1  load NZCV/FP status
- flags_in  in  10  {N,C,Z,V,FP_Status[5:0]}
- cpsr_wr  in  1  full CPSR write (MSR)
- cpsr_din  in  DW  CPSR write data
- CPSR_out  out  DW  current CPSR
- cur_mode  out  3  CPSR mode field
- busy  out  1  state != IDLE; control unit stalls
- exc_ack  out  1  one-cycle entry acknowledge
- exc_vec  out  DW  VEC_BASE + (k<<3) while exc_ack, else 0
- ret_valid  out  1  one-cycle return strobe
- ret_addr  out  DW  LR[mode] while ret_valid, else 0
- ret_err  out  1  one-cycle strobe: ret_req in mode 0

## Operation

- CPSR layout: [5:0] FP_Status, [9:6] N,C,Z,V, [12:10] mode, [13+j] mask for source j, rest zero. cpsr_wr forces reserved bits to 0.
- Eligible source: irq_req[j]=1, mask[j]=0, j+1 > cur_mode. The highest eligible j wins.
- FSM states IDLE, SAVE, SWITCH, RESTORE.
- IDLE: eligible source present → latch k=j, go to SAVE. Else if ret_req and mode≠0 → RESTORE. Else if ret_req and mode=0 → ret_err pulse, stay in IDLE.
- Simultaneous interrupt and return: the interrupt wins. ret_req stays pending and is serviced after the handler.
- SAVE: SPSR[k+1] <= CPSR, LR[k+1] <= pc_in → SWITCH.
- SWITCH: CPSR.mode <= k+1, mask[0..k] <= 1, exc_ack=1, exc_vec valid → IDLE.
- RESTORE: CPSR <= SPSR[mode], ret_valid=1, ret_addr=LR[mode] → IDLE.
- In IDLE with no transition starting: cpsr_wr loads CPSR, else flags_ld loads [9:0].
- In the IDLE cycle that starts a transition, flags_ld/cpsr_wr still apply, and SAVE captures the updated CPSR.
- When busy=1, flags_ld and cpsr_wr are ignored.
- Bank index 0 is unused: SPSR/LR exist only for modes 1..NMODES-1.

## Timing

- Reset values: CPSR = all mask bits 1, mode 0, flags 0. SPSR and LR banks 0. FSM in IDLE. busy, exc_ack, ret_valid, ret_err = 0. exc_vec, ret_addr = 0.
- Entry: request sampled in IDLE at cycle t. SAVE at t+1, SWITCH at t+2 with exc_ack. New CPSR visible at t+3.
- Return: ret_req at t. RESTORE at t+1 with ret_valid and ret_addr. Restored CPSR visible at t+2.
- ret_err is asserted in cycle t+1, registered.
- Strobes are Moore outputs of the state, except ret_err, which is registered.
- A request dropped before acknowledge but after latching still completes entry (k is latched).
- Reset mid-sequence aborts immediately to reset values. No partial bank write survives beyond a completed edge.

## Structure

- psr_pkg holds:
  - state enum
  - CPSR field offsets (FPS_LSB, NZCV_LSB, MODE_LSB, MASK_LSB)
  - MODE_W=3
  - vector stride constant VEC_SHIFT=3
- Sub-module psr_prio_enc: combinational masked priority encoder (NSRC inputs, mask, cur_mode) → valid, index.

## Test plan

- Reset, then cpsr_wr 32'h0000_0000 (unmask all), assert irq_req=3'b001 → exc_ack at +3 cycles, exc_vec=32'h100, cur_mode=1, SPSR[1]=0, LR[1]=pc_in.
- In mode 1 assert irq_req=3'b101 → source 2 enters mode 3, exc_vec=32'h110, mask bits [15:13]=3'b111.
- Return from mode 3 → ret_valid, ret_addr=LR[3], CPSR restored to the mode-1 value. A second return yields mode 0 CPSR.
- irq_req and ret_req in the same cycle in mode 1 with source 1 eligible → entry to mode 2 first; the return is serviced after the next return completes.
- ret_req in mode 0 → ret_err pulse one cycle later, CPSR unchanged; flags_ld while busy → ignored.
- Assert reset during SAVE → all outputs are reset values next cycle, LR bank still 0.
